// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, receiver FSM encoding and
// bit-timing derivation, common to the receiver and the transmitter.
package uart_pkg;

    // Parity selection
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Receiver FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_BREAK = 3'd5;

    // System clocks per line bit, truncated
    function automatic int unsigned clk_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Offset of the centre sample within a bit
    function automatic int unsigned half_bit(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_per_bit(clk_hz, baud) / 2;
    endfunction

    // Width of a counter covering 0..cpb-1
    function automatic int unsigned cnt_width(input int unsigned cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, falling-edge detector and 3-sample majority voter.
// The voted value is presented on the cycle the bit counter reaches HALF_BIT+1.
module uart_rx_sampler #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned HALF_BIT    = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             rx_port,
    input  logic [CNT_W-1:0] bit_cnt,
    output logic             line_sync,
    output logic             line_fell,
    output logic             vote,
    output logic             vote_stb
);

    localparam logic [CNT_W-1:0] CNT_S0 = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_S1 = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_S2 = CNT_W'(HALF_BIT + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   s0_q, s0_d;
    logic                   s1_q, s1_d;

    assign line_sync = sync_q[SYNC_STAGES-1];
    assign line_fell = edge_q & ~line_sync;
    assign vote_stb  = (bit_cnt == CNT_S2);
    assign vote      = (s0_q & s1_q) | (s0_q & line_sync) | (s1_q & line_sync);

    // Next state: shift the line in, remember the first two vote samples
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_port};
        edge_d = line_sync;
        s0_d   = s0_q;
        s1_d   = s1_q;
        if (bit_cnt == CNT_S0) s0_d = line_sync;
        if (bit_cnt == CNT_S1) s1_d = line_sync;
    end

    // State: everything resets to the idle (high) line level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '1;
            edge_q <= 1'b1;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with parity/framing/break detection and a
// single-entry valid/ready output holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 200000000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx_port,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int unsigned CLK_PER_BIT = clk_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HALF_BIT    = half_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W       = cnt_width(CLK_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == PAR_ODD);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 zero_q, zero_d;     // every bit so far sampled low
    logic                 perr_q, perr_d;     // pending parity error
    logic                 ferr_q, ferr_d;     // pending framing error
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 break_q, break_d;

    logic deliver;
    logic del_ferr;
    logic line_sync, line_fell, vote, vote_stb;

    uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .HALF_BIT    (HALF_BIT)
    ) u_sampler (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_port   (rx_port),
        .bit_cnt   (cnt_q),
        .line_sync (line_sync),
        .line_fell (line_fell),
        .vote      (vote),
        .vote_stb  (vote_stb)
    );

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;
    assign busy       = (state_q != ST_IDLE);

    // Frame FSM, bit timing and output holding register
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        zero_d       = zero_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        break_d      = 1'b0;
        deliver      = 1'b0;
        del_ferr     = ferr_q;

        // Counter free-runs across bits so sample points stay one bit apart
        if (state_q == ST_IDLE || state_q == ST_BREAK) begin
            cnt_d = '0;
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (line_fell) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    zero_d  = 1'b1;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (vote_stb) state_d = vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (vote_stb) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (vote) zero_d = 1'b0;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_PAR: begin
                if (vote_stb) begin
                    if (vote) zero_d = 1'b0;
                    perr_d  = ((^shift_q) ^ vote) != ODD_PAR;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (vote_stb) begin
                    if (idx_q == '0 && zero_q && !vote) begin
                        // Line held low through the first stop bit: break
                        break_d  = 1'b1;
                        deliver  = 1'b1;
                        del_ferr = 1'b1;
                        state_d  = ST_BREAK;
                    end else begin
                        if (!vote) ferr_d = 1'b1;
                        if (idx_q == LAST_STOP) begin
                            deliver  = 1'b1;
                            del_ferr = ferr_q | ~vote;
                            state_d  = ST_IDLE;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (line_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A frame is only loaded into a free (or just-accepted) register
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = perr_q;
                frame_err_d  = del_ferr;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            zero_q       <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            zero_q       <= zero_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            break_q      <= break_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E1 instance at 16 clocks per bit.
module tb_uart_rx_param;

    localparam int CPB  = 16;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_n, rx_e, ready_n, ready_e;
    logic [7:0] rx_data_n, rx_data_e;
    logic       rx_valid_n, rx_valid_e;
    logic       perr_n, perr_e, ferr_n, ferr_e;
    logic       overrun_n, overrun_e, break_det_n, break_det_e, busy_n, busy_e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         deliv_n = 0, ovr_n = 0, brk_n = 0, ovr_e = 0, brk_e = 0;
    int         rise_cyc_n = 0;
    logic [7:0] rise_data_n = '0;
    logic       rise_perr_n = 1'b0, rise_ferr_n = 1'b0, prev_valid_n = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(
        .CLK_HZ (1600000), .BAUD (100000), .DATA_BITS (8),
        .PARITY (0), .STOP_BITS (1), .SYNC_STAGES (2)
    ) u_dut_n (
        .sys_clk (clk), .sys_rst_n (rst_n), .rx_port (rx_n),
        .rx_data (rx_data_n), .rx_valid (rx_valid_n), .rx_ready (ready_n),
        .parity_err (perr_n), .frame_err (ferr_n), .overrun (overrun_n),
        .break_det (break_det_n), .busy (busy_n)
    );

    uart_rx_param #(
        .CLK_HZ (1600000), .BAUD (100000), .DATA_BITS (8),
        .PARITY (1), .STOP_BITS (1), .SYNC_STAGES (2)
    ) u_dut_e (
        .sys_clk (clk), .sys_rst_n (rst_n), .rx_port (rx_e),
        .rx_data (rx_data_e), .rx_valid (rx_valid_e), .rx_ready (ready_e),
        .parity_err (perr_e), .frame_err (ferr_e), .overrun (overrun_e),
        .break_det (break_det_e), .busy (busy_e)
    );

    // Delivery and pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid_n && !prev_valid_n) begin
            deliv_n++;
            rise_cyc_n  = cyc;
            rise_data_n = rx_data_n;
            rise_perr_n = perr_n;
            rise_ferr_n = ferr_n;
        end
        prev_valid_n = rx_valid_n;
        if (overrun_n)   ovr_n++;
        if (break_det_n) brk_n++;
        if (overrun_e)   ovr_e++;
        if (break_det_e) brk_e++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input bit e, input logic v);
        if (e) rx_e = v;
        else   rx_n = v;
    endtask

    // Drive one frame; spike_bit >= 0 inverts the line for one clock at spike_off
    task automatic send_frame(input bit e, input logic [7:0] data, input logic pbit,
                              input logic stop, input int spike_bit, input int spike_off);
        logic [10:0] bits;
        int          n;
        logic        v;
        n    = e ? 11 : 10;
        bits = e ? {stop, pbit, data, 1'b0} : {1'b1, stop, data, 1'b0};
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < CPB; k++) begin
                v = bits[i];
                if (i == spike_bit && k == spike_off) v = ~v;
                set_line(e, v);
                @(negedge clk);
            end
        end
        set_line(e, 1'b1);
    endtask

    task automatic gap();
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic wait_valid(input bit e, input string name);
        int t = 0;
        while (((e ? rx_valid_e : rx_valid_n) == 1'b0) && t < 4 * CPB) begin
            @(negedge clk);
            t++;
        end
        if ((e ? rx_valid_e : rx_valid_n) == 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: rx_valid timeout, got 0, expected 1", name);
        end
    endtask

    task automatic accept(input bit e, input string name);
        if (e) ready_e = 1'b1; else ready_n = 1'b1;
        @(negedge clk);
        if (e) ready_e = 1'b0; else ready_n = 1'b0;
        check(name, 32'(e ? rx_valid_e : rx_valid_n), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         d0, b0, o0, t0;
        logic [7:0] rd;
        logic       rp, rs, ep;
        logic [9:0] fb;

        vecs[0] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; rx_n = 1'b1; rx_e = 1'b1; ready_n = 1'b0; ready_e = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data",  32'(rx_data_n), 0);
        check("rst_valid", 32'({rx_valid_n, rx_valid_e}), 0);
        check("rst_flags", 32'({perr_n, ferr_n, overrun_n, break_det_n}), 0);
        check("rst_busy",  32'({busy_n, busy_e}), 0);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        check("no_false_start", 32'({busy_n, busy_e}), 0);

        // 8N1 0x55 with ready high: valid one cycle after the stop sample
        ready_n = 1'b1;
        d0 = deliv_n;
        t0 = cyc;
        send_frame(0, 8'h55, 1'b0, 1'b1, -1, 0);
        gap();
        check("55_deliv",   32'(deliv_n), 32'(d0 + 1));
        check("55_latency", 32'(rise_cyc_n - t0), 32'(CPB * 9 + HALF + 5));
        check("55_data",    32'(rise_data_n), 32'h55);
        check("55_flags",   32'({rise_perr_n, rise_ferr_n}), 0);
        check("55_cleared", 32'(rx_valid_n), 0);

        // Stop bit low on 0x0F: framing error, no break
        d0 = deliv_n; b0 = brk_n;
        send_frame(0, 8'h0F, 1'b0, 1'b0, -1, 0);
        gap();
        check("0f_deliv", 32'(deliv_n), 32'(d0 + 1));
        check("0f_data",  32'(rise_data_n), 32'h0F);
        check("0f_ferr",  32'(rise_ferr_n), 1);
        check("0f_nobrk", 32'(brk_n), 32'(b0));

        // Line low for 12 bit times: one break, one delivery, then silence
        d0 = deliv_n; b0 = brk_n;
        rx_n = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("brk_pulse", 32'(brk_n), 32'(b0 + 1));
        check("brk_deliv", 32'(deliv_n), 32'(d0 + 1));
        check("brk_ferr",  32'(rise_ferr_n), 1);
        check("brk_data",  32'(rise_data_n), 0);
        check("brk_busy",  32'(busy_n), 1);
        rx_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("brk_nodeliv", 32'(deliv_n), 32'(d0 + 1));
        check("brk_idle",    32'(busy_n), 0);

        // 6-clock glitch: start seen, rejected by count HALF+2
        d0 = deliv_n;
        rx_n = 1'b0;
        repeat (6) @(negedge clk);
        rx_n = 1'b1;
        check("glitch_busy", 32'(busy_n), 1);
        repeat (7) @(negedge clk);
        check("glitch_idle", 32'(busy_n), 0);
        repeat (3 * CPB) @(negedge clk);
        check("glitch_nodeliv", 32'(deliv_n), 32'(d0));

        // Overrun: second frame dropped while the first is held
        ready_n = 1'b0;
        d0 = deliv_n; o0 = ovr_n;
        send_frame(0, 8'h11, 1'b0, 1'b1, -1, 0);
        gap();
        send_frame(0, 8'h22, 1'b0, 1'b1, -1, 0);
        gap();
        check("ovr_pulse", 32'(ovr_n), 32'(o0 + 1));
        check("ovr_deliv", 32'(deliv_n), 32'(d0 + 1));
        check("ovr_data",  32'(rx_data_n), 32'h11);
        check("ovr_valid", 32'(rx_valid_n), 1);
        accept(0, "ovr_accept");

        // One-clock spike on the centre sample of data bit 0
        send_frame(0, 8'hF0, 1'b0, 1'b1, 1, 9);
        gap();
        wait_valid(0, "spike_wait");
        check("spike_data", 32'(rx_data_n), 32'hF0);
        accept(0, "spike_accept");

        // Even-parity table
        for (int i = 0; i < 7; i++) begin
            send_frame(1, vecs[i].data, vecs[i].pbit, vecs[i].stop, -1, 0);
            gap();
            wait_valid(1, "tbl_wait");
            check($sformatf("tbl%0d_data", i), 32'(rx_data_e), 32'(vecs[i].data));
            check($sformatf("tbl%0d_perr", i), 32'(perr_e), 32'(vecs[i].exp_perr));
            check($sformatf("tbl%0d_ferr", i), 32'(ferr_e), 32'(vecs[i].exp_ferr));
            accept(1, "tbl_accept");
        end

        // Random 8E1 frames against the parity/stop rules
        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) != 0);
            if (rd == 8'h00 && !rp) rs = 1'b1;
            ep = (($countones(rd) + int'(rp)) % 2) != 0;
            send_frame(1, rd, rp, rs, -1, 0);
            gap();
            wait_valid(1, "rnd_e_wait");
            check("rnd_e_data", 32'(rx_data_e), 32'(rd));
            check("rnd_e_perr", 32'(perr_e), 32'(ep));
            check("rnd_e_ferr", 32'(ferr_e), 32'(!rs));
            accept(1, "rnd_e_accept");
        end
        check("e_no_overrun", 32'(ovr_e), 0);
        check("e_no_break",   32'(brk_e), 0);

        // Random 8N1 frames, each with a one-clock spike somewhere in the data
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom_range(1, 255));
            send_frame(0, rd, 1'b0, 1'b1, $urandom_range(1, 8), $urandom_range(0, CPB - 1));
            gap();
            wait_valid(0, "rnd_n_wait");
            check("rnd_n_data",  32'(rx_data_n), 32'(rd));
            check("rnd_n_flags", 32'({perr_n, ferr_n}), 0);
            accept(0, "rnd_n_accept");
        end

        // Reset during data bit 4 with a frame held, then a clean 0x3C
        send_frame(0, 8'h5A, 1'b0, 1'b1, -1, 0);
        gap();
        fb = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_n = fb[i];
            repeat (CPB) @(negedge clk);
        end
        rx_n = fb[5];
        repeat (8) @(negedge clk);
        check("mid_busy",  32'(busy_n), 1);
        check("mid_valid", 32'(rx_valid_n), 1);
        rst_n = 1'b0;
        #1;
        check("mrst_data",  32'(rx_data_n), 0);
        check("mrst_valid", 32'(rx_valid_n), 0);
        check("mrst_flags", 32'({perr_n, ferr_n, overrun_n, break_det_n}), 0);
        check("mrst_busy",  32'(busy_n), 0);
        @(negedge clk);
        rx_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap();
        send_frame(0, 8'h3C, 1'b0, 1'b1, -1, 0);
        gap();
        wait_valid(0, "post_rst_wait");
        check("post_rst_data",  32'(rx_data_n), 32'h3C);
        check("post_rst_flags", 32'({perr_n, ferr_n}), 0);
        accept(0, "post_rst_accept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 200000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning line bit rate.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, legal 5..9, meaning payload bits per frame.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, legal 1..2, meaning stop bits checked per frame.
REQ-006 The block SHALL have parameter SYNC_STAGES, default 2, legal >=2, meaning rx_port synchroniser depth.
REQ-007 The block SHALL have port sys_clk, input, 1, system clock; all logic is on its rising edge.
REQ-008 The block SHALL have port sys_rst_n, input, 1, reset (asynchronous, active-low).
REQ-009 The block SHALL have port rx_port, input, 1, asynchronous serial line, idle high.
REQ-010 The block SHALL have port rx_data, output, DATA_BITS, received payload with LSB received first.
REQ-011 The block SHALL have port rx_valid, output, 1, rx_data and error flags valid.
REQ-012 The block SHALL have port rx_ready, input, 1, consumer accepts rx_data.
REQ-013 The block SHALL have port parity_err, output, 1, parity mismatch for the held frame.
REQ-014 The block SHALL have port frame_err, output, 1, a stop bit sampled low for the held frame.
REQ-015 The block SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-016 The block SHALL have port break_det, output, 1, one-cycle pulse on break detection.
REQ-017 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-018 CLK_PER_BIT SHALL equal CLK_HZ/BAUD with integer truncation, and HALF_BIT SHALL equal CLK_PER_BIT/2; the bit counter is sized to $clog2(CLK_PER_BIT).
REQ-019 rx_port SHALL pass through SYNC_STAGES flops plus one edge-detect flop; a start condition is the synchronised line going from 1 to 0 while in IDLE.
REQ-020 The FSM states SHALL be IDLE, START, DATA, PAR, STOP, BREAK.
REQ-021 Transition IDLE->START SHALL occur on a start condition, with the bit counter cleared.
REQ-022 Every sample SHALL be a majority vote of 3 synchronised samples taken at counts HALF_BIT-1, HALF_BIT and HALF_BIT+1, and the voted value SHALL be committed at HALF_BIT+1.
REQ-023 In START, a voted start bit of 1 SHALL be treated as a glitch and return the FSM to IDLE with no output change; a voted 0 SHALL proceed to DATA.
REQ-024 In DATA, one bit SHALL be shifted per CLK_PER_BIT, LSB first; after DATA_BITS bits the FSM goes to PAR if PARITY!=0, else to STOP.
REQ-025 In PAR, the sampled bit SHALL be checked: even parity means XOR(data, parity bit)==0 and odd parity means ==1; a mismatch sets the pending parity error.
REQ-026 In STOP, STOP_BITS samples SHALL be taken, and any 0 sets the pending frame error.
REQ-027 One cycle after the last stop sample, the frame SHALL be delivered and the FSM SHALL return to IDLE, so the next start edge is accepted within the remaining half stop bit.
REQ-028 Break condition: all data bits, the parity bit (if present) and the first stop bit are 0; in this case break_det SHALL pulse, frame_err SHALL be set, and the FSM SHALL enter BREAK, staying there until the synchronised line reads 1, then IDLE.
REQ-029 Delivery when rx_valid is 0 SHALL load rx_data, parity_err and frame_err and set rx_valid.
REQ-030 Delivery when rx_valid is 1 and rx_ready is 0 SHALL discard the new frame, pulse overrun, and leave the held outputs unchanged.
REQ-031 rx_valid SHALL clear on the cycle after rx_valid&&rx_ready; if a delivery coincides with the handshake, the new frame SHALL be loaded and rx_valid SHALL stay 1 with no overrun.
REQ-032 rx_data and the error flags SHALL be stable while rx_valid is 1 and not yet accepted.

Reset
REQ-033 Asserting sys_rst_n low at any time, including mid-frame, SHALL force the FSM to IDLE and clear the counters and shift register.
REQ-034 During reset, rx_data SHALL be 0, and rx_valid, parity_err, frame_err, overrun, break_det and busy SHALL be 0.
REQ-035 The synchroniser and edge flops SHALL reset to 1 (line idle), so that the release of reset never produces a false start.

Structure
REQ-036 The parity encoding constants, FSM state encoding and the CLK_PER_BIT/HALF_BIT derivation SHALL reside in the shared package uart_pkg, reused by the transmitter.
REQ-037 The synchroniser plus 3-sample majority voter SHALL be the single sub-module uart_rx_sampler; everything else stays in uart_rx_param.

Verification (CLK_PER_BIT=16 for speed)
REQ-038 Bench SHALL check 8N1 frame 0x55 with rx_ready=1 -> rx_valid one cycle after the stop sample, rx_data=0x55, no error flags.
REQ-039 Bench SHALL check PARITY=1 with frame 0xA3 and parity bit 1 -> rx_data=0xA3, parity_err=1; the same frame with parity 0 -> parity_err=0.
REQ-040 Bench SHALL check a stop bit driven low on frame 0x0F -> frame_err=1 and break_det=0; a line low for 12 bit times -> break_det pulses once, frame_err=1, and there is no further delivery until the line returns high.
REQ-041 Bench SHALL check rx_ready=0 with frames 0x11 then 0x22 -> overrun pulse at the second delivery and rx_data still 0x11; raise rx_ready -> rx_valid drops.
REQ-042 Bench SHALL check a 6-clock low glitch on an idle line -> no rx_valid and busy back to 0 by count HALF_BIT+2; a single-clock spike inside a data bit -> the bit is still decoded correctly.
REQ-043 Bench SHALL check reset asserted during data bit 4 -> all outputs 0 and FSM IDLE; after release, a clean 0x3C frame is received correctly.
